// File: rtl/sprite_pkg.sv
// Constants and enums shared by the sprite RAM write engine and its RAM model.
package sprite_pkg;

  localparam int          SPRITE_WIDTH_X       = 32;
  localparam int          SPRITE_HEIGHT_Y      = 32;
  localparam int          SPRITE_PIX_W         = 8;
  localparam logic [7:0]  TRANSPARENT_ENCODING = 8'hFF;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_FILL = 2'b01,
    OP_POKE = 2'b10,
    OP_RSVD = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FILL,
    ST_POKE,
    ST_DONE
  } wr_state_e;

endpackage

// File: rtl/sprite_ram.sv
// Dual-port sprite RAM: synchronous write port, registered read port addressed by {offsetY, offsetX}.
module sprite_ram #(
  parameter int XW = 5,
  parameter int YW = 5,
  parameter int DW = 8,
  localparam int AW = XW + YW
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [XW-1:0] offset_x_i,
  input  logic [YW-1:0] offset_y_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [2**AW];

  // Read-during-write to the same address returns the old contents.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rd_data_o <= mem_q[{offset_y_i, offset_x_i}];
  end

endmodule

// File: rtl/sprite_ram_writer.sv
// Write-side engine for the sprite RAM: LOAD streams a sprite, FILL paints a constant colour, POKE sets one pixel.
module sprite_ram_writer
  import sprite_pkg::*;
#(
  parameter int WIDTH_X  = SPRITE_WIDTH_X,
  parameter int HEIGHT_Y = SPRITE_HEIGHT_Y,
  parameter int PIX_W    = SPRITE_PIX_W,
  localparam int XW = $clog2(WIDTH_X),
  localparam int YW = $clog2(HEIGHT_Y),
  localparam int AW = XW + YW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [XW-1:0]    cmd_x,
  input  logic [YW-1:0]    cmd_y,
  input  logic [PIX_W-1:0] cmd_data,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_ready,
  input  logic             abort,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [PIX_W-1:0] wr_data,
  output logic             busy,
  output logic             done
);

  wr_state_e        state_q;
  logic [XW-1:0]    x_q;
  logic [YW-1:0]    y_q;
  logic [PIX_W-1:0] color_q;
  logic             last_q;
  logic             wr_en_q;
  logic [AW-1:0]    wr_addr_q;
  logic [PIX_W-1:0] wr_data_q;
  logic             x_end;
  logic             y_end;

  assign x_end = (x_q == XW'(WIDTH_X - 1));
  assign y_end = (y_q == YW'(HEIGHT_Y - 1));

  // last_q marks the cycle in which the final write is on the bus; DONE follows it
  // so the done pulse never overlaps a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      color_q   <= '0;
      last_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            color_q <= cmd_data;
            x_q     <= '0;
            y_q     <= '0;
            last_q  <= 1'b0;
            unique case (cmd_op_e'(cmd_op))
              OP_LOAD: state_q <= ST_LOAD;
              OP_FILL: state_q <= ST_FILL;
              OP_POKE: begin
                state_q <= ST_POKE;
                x_q     <= cmd_x;
                y_q     <= cmd_y;
              end
              default: state_q <= ST_DONE;
            endcase
          end
        end
        ST_LOAD, ST_FILL: begin
          if (abort) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            last_q  <= 1'b0;
          end else if (last_q) begin
            state_q <= ST_DONE;
            last_q  <= 1'b0;
          end else if (state_q == ST_FILL || pix_valid) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= {y_q, x_q};
            wr_data_q <= (state_q == ST_FILL) ? color_q : pix_data;
            x_q       <= x_end ? '0 : x_q + 1'b1;
            if (x_end) y_q <= y_q + 1'b1;
            if (x_end && y_end) last_q <= 1'b1;
          end
        end
        ST_POKE: begin
          if (last_q) begin
            state_q <= ST_DONE;
            last_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= {y_q, x_q};
            wr_data_q <= color_q;
            last_q    <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign pix_ready = (state_q == ST_LOAD) && !last_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_sprite_ram_writer.sv
// Directed + randomized bench for sprite_ram_writer with a sprite_ram alongside and a memory reference model.
module tb_sprite_ram_writer;
  import sprite_pkg::*;

  localparam int NPIX = SPRITE_WIDTH_X * SPRITE_HEIGHT_Y;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [4:0] cmd_x, cmd_y;
  logic [7:0] cmd_data;
  logic       pix_valid, pix_ready;
  logic [7:0] pix_data;
  logic       abort;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy, done;
  logic [4:0] rd_x, rd_y;
  logic [7:0] rd_data;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] model_mem [NPIX];

  always #5 clk = ~clk;

  sprite_ram_writer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_data(cmd_data),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .abort(abort),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  sprite_ram #(.XW(5), .YW(5), .DW(8)) u_ram (
    .clk_i(clk), .we_i(wr_en), .waddr_i(wr_addr), .wdata_i(wr_data),
    .offset_x_i(rd_x), .offset_y_i(rd_y), .rd_data_o(rd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input string tag, input int addr, input logic [7:0] data);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd1);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'(addr));
    chk({tag, "_wr_data"}, 32'(wr_data), 32'(data));
    model_mem[addr] = data;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [4:0] x, input logic [4:0] y,
                          input logic [7:0] d);
    int waited;
    waited = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_data = d;
    while (!cmd_ready && waited < 20) begin
      cyc();
      waited++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic rd_chk(input int addr);
    logic [9:0] a;
    a = 10'(addr);
    rd_x = a[4:0];
    rd_y = a[9:5];
    cyc();
    chk("ram_readback", 32'(rd_data), 32'(model_mem[addr]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c, d;
    logic       v;
    int         p;

    cmd_valid = 1'b0; cmd_op = OP_LOAD; cmd_x = '0; cmd_y = '0; cmd_data = '0;
    pix_valid = 1'b0; pix_data = '0; abort = 1'b0; rd_x = '0; rd_y = '0;

    // Reset values, and commands ignored while reset is held.
    #1 reset = 1'b1;
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = OP_POKE; cmd_data = 8'h55;
    cyc(); cyc();
    chk("rst_cmd_ignored_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ignored_wr", 32'(wr_en), 32'd0);
    cmd_valid = 1'b0;
    reset = 1'b0;
    cyc();

    // 1: FILL with the transparent colour.
    send_cmd(OP_FILL, 5'd0, 5'd0, TRANSPARENT_ENCODING);
    chk("fill_cmd_ready_low", 32'(cmd_ready), 32'd0);
    for (int k = 0; k < NPIX; k++) begin
      cyc();
      expect_write("fill", k, TRANSPARENT_ENCODING);
      chk("fill_no_early_done", 32'(done), 32'd0);
    end
    cyc();
    chk("fill_done", 32'(done), 32'd1);
    chk("fill_done_no_wr", 32'(wr_en), 32'd0);
    chk("fill_done_busy", 32'(busy), 32'd1);
    chk("fill_done_not_ready", 32'(cmd_ready), 32'd0);
    cyc();
    chk("fill_done_one_cycle", 32'(done), 32'd0);
    chk("fill_ready_after", 32'(cmd_ready), 32'd1);
    rd_chk(0); rd_chk(517); rd_chk(NPIX - 1);

    // 2: POKE x=5 y=3; abort held during it must have no effect.
    send_cmd(OP_POKE, 5'd5, 5'd3, 8'hB1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    expect_write("poke", 101, 8'hB1);
    chk("poke_no_done_yet", 32'(done), 32'd0);
    cyc();
    chk("poke_done", 32'(done), 32'd1);
    chk("poke_done_no_wr", 32'(wr_en), 32'd0);
    cyc();
    chk("poke_ready", 32'(cmd_ready), 32'd1);
    chk("poke_no_extra_wr", 32'(wr_en), 32'd0);
    rd_chk(101);

    // 3: LOAD with a pixel every other cycle, data = low address bits.
    send_cmd(OP_LOAD, 5'd0, 5'd0, 8'h00);
    for (int k = 0; k < NPIX; k++) begin
      pix_valid = 1'b1;
      pix_data  = 8'(k);
      chk("load_pix_ready", 32'(pix_ready), 32'd1);
      chk("load_cmd_ready_low", 32'(cmd_ready), 32'd0);
      cyc();
      pix_valid = 1'b0;
      expect_write("load", k, 8'(k));
      cyc();
      chk("load_gap_no_wr", 32'(wr_en), 32'd0);
      chk("load_done", 32'(done), (k == NPIX - 1) ? 32'd1 : 32'd0);
    end
    cyc();
    chk("load_ready_after", 32'(cmd_ready), 32'd1);
    rd_chk(300); rd_chk(1000);

    // 4: abort a FILL once address 499 has been written.
    c = 8'($urandom);
    send_cmd(OP_FILL, 5'd0, 5'd0, c);
    for (int k = 0; k < 500; k++) begin
      cyc();
      expect_write("afill", k, c);
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_no_wr", 32'(wr_en), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("abort_quiet_wr", 32'(wr_en), 32'd0);
      chk("abort_quiet_done", 32'(done), 32'd0);
    end
    d = 8'($urandom);
    send_cmd(OP_POKE, 5'd0, 5'd0, d);
    cyc();
    expect_write("abort_poke", 0, d);
    cyc(); cyc();
    rd_chk(0); rd_chk(499); rd_chk(500);

    // 5: reset pulsed mid-LOAD at pixel 300, then a gappy random LOAD.
    send_cmd(OP_LOAD, 5'd0, 5'd0, 8'h00);
    for (int k = 0; k < 300; k++) begin
      pix_valid = 1'b1;
      pix_data  = 8'($urandom);
      d = pix_data;
      cyc();
      expect_write("rload", k, d);
    end
    pix_data = 8'($urandom);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_wr_en", 32'(wr_en), 32'd0);
    chk("async_rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("async_rst_wr_data", 32'(wr_data), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("async_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    pix_valid = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    send_cmd(OP_LOAD, 5'd0, 5'd0, 8'h00);
    p = 0;
    for (int n = 0; n < 4000 && p < NPIX; n++) begin
      v = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      pix_valid = v;
      pix_data  = d;
      cyc();
      if (v) begin
        expect_write("gload", p, d);
        p++;
      end else begin
        chk("gload_gap", 32'(wr_en), 32'd0);
      end
    end
    pix_valid = 1'b0;
    chk("gload_count", 32'(p), 32'(NPIX));
    cyc();
    chk("gload_done", 32'(done), 32'd1);
    cyc();
    chk("gload_ready", 32'(cmd_ready), 32'd1);
    for (int k = 0; k < 16; k++) rd_chk(int'($urandom_range(0, NPIX - 1)));

    // 6: FILL held on the command port while a POKE runs, then reserved op.
    send_cmd(OP_POKE, 5'd31, 5'd31, 8'h3C);
    c = 8'($urandom);
    cmd_valid = 1'b1; cmd_op = OP_FILL; cmd_data = c;
    cyc();
    expect_write("hold_poke", NPIX - 1, 8'h3C);
    chk("hold_not_ready", 32'(cmd_ready), 32'd0);
    cyc();
    chk("hold_poke_done", 32'(done), 32'd1);
    chk("hold_poke_done_no_wr", 32'(wr_en), 32'd0);
    cyc();
    chk("hold_idle_ready", 32'(cmd_ready), 32'd1);
    chk("hold_idle_no_wr", 32'(wr_en), 32'd0);
    cyc();
    cmd_valid = 1'b0;
    chk("hold_fill_accepted", 32'(busy), 32'd1);
    chk("hold_fill_first_wait", 32'(wr_en), 32'd0);
    cyc();
    expect_write("hold_fill", 0, c);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("hold_fill_aborted", 32'(cmd_ready), 32'd1);
    send_cmd(OP_RSVD, 5'd0, 5'd0, 8'h00);
    chk("rsvd_done", 32'(done), 32'd1);
    chk("rsvd_no_wr", 32'(wr_en), 32'd0);
    chk("rsvd_busy", 32'(busy), 32'd1);
    cyc();
    chk("rsvd_done_clear", 32'(done), 32'd0);
    chk("rsvd_ready", 32'(cmd_ready), 32'd1);
    chk("rsvd_still_no_wr", 32'(wr_en), 32'd0);
    rd_chk(NPIX - 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
